// File: rtl/btn_event_uart_tx.sv
// Button event packetiser: debounced ticks -> event FIFO -> UART write strobes.
// Optional macro BTN_EVT_SEQ_EN appends an 8-bit sequence byte after each code byte.
module btn_event_uart_tx #(
    parameter int          NUM_BTN    = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter int          ADDR_W     = 3,
    parameter logic [7:0]  CODE_BASE  = 8'h30
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_tick,
    input  logic               tx_full,
    output logic               write_uart,
    output logic [7:0]         write_data,
    output logic [ADDR_W:0]    fifo_count,
    output logic               overflow
);

    localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);

`ifdef BTN_EVT_SEQ_EN
    typedef enum logic [1:0] {S_IDLE, S_CODE, S_GAP, S_SEQ} state_t;
    logic [7:0] seq_q, seq_d;
`else
    typedef enum logic {S_IDLE, S_ISSUE} state_t;
`endif

    state_t state_q, state_d;

    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [NUM_BTN-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_pend;
    logic               push, pop;
    logic [7:0]         push_data;
    logic               ovf_q, ovf_d;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               fifo_full, fifo_empty;

    logic               wu_q, wu_d;
    logic [7:0]         wd_q, wd_d;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // Priority arbiter: lowest pending index wins a FIFO slot; coalesced ticks flag overflow
    always_comb begin
        grant_idx = '0;
        any_pend  = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_idx = IDX_W'(i);
                any_pend  = 1'b1;
            end
        end
        push  = any_pend && !fifo_full;
        grant = '0;
        if (push) begin
            grant[grant_idx] = 1'b1;
        end
        push_data = CODE_BASE + 8'(grant_idx);
        pending_d = (pending_q & ~grant) | btn_tick;
        ovf_d     = ovf_q | (|(btn_tick & pending_q & ~grant));
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifdef BTN_EVT_SEQ_EN
    // Drain FSM: code strobe pops the head, then a gap, then the sequence strobe
    always_comb begin
        state_d = state_q;
        wu_d    = 1'b0;
        wd_d    = wd_q;
        pop     = 1'b0;
        seq_d   = seq_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !tx_full) begin
                    pop     = 1'b1;
                    wu_d    = 1'b1;
                    wd_d    = mem_q[rd_ptr_q];
                    state_d = S_CODE;
                end
            end
            S_CODE: state_d = S_GAP;
            S_GAP: begin
                if (!tx_full) begin
                    wu_d    = 1'b1;
                    wd_d    = seq_q;
                    seq_d   = seq_q + 8'd1;
                    state_d = S_SEQ;
                end
            end
            S_SEQ:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
`else
    // Drain FSM: one registered strobe, then a mandatory idle cycle
    always_comb begin
        state_d = state_q;
        wu_d    = 1'b0;
        wd_d    = wd_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !tx_full) begin
                    pop     = 1'b1;
                    wu_d    = 1'b1;
                    wd_d    = mem_q[rd_ptr_q];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
`endif

    // Event storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wu_q      <= 1'b0;
            wd_q      <= 8'h00;
`ifdef BTN_EVT_SEQ_EN
            seq_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wu_q      <= wu_d;
            wd_q      <= wd_d;
`ifdef BTN_EVT_SEQ_EN
            seq_q     <= seq_d;
`endif
        end
    end

    assign write_uart = wu_q;
    assign write_data = wd_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_btn_event_uart_tx.sv
// Self-checking bench for btn_event_uart_tx: queue-based reference model plus
// directed scenarios with literal expectations (sequence mode via BTN_EVT_SEQ_EN).
module tb_btn_event_uart_tx;

    localparam int NB = 4;
    localparam int D  = 8;
`ifdef BTN_EVT_SEQ_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif
    localparam int GAP = SEQ ? 4 : 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_tick = '0;
    logic          tx_full = 1'b0;
    logic          write_uart;
    logic [7:0]    write_data;
    logic [3:0]    fifo_count;
    logic          overflow;

    btn_event_uart_tx #(
        .NUM_BTN(NB), .FIFO_DEPTH(D), .ADDR_W(3), .CODE_BASE(8'h30)
    ) dut (
        .clk_100MHz(clk),
        .reset(reset),
        .btn_tick(btn_tick),
        .tx_full(tx_full),
        .write_uart(write_uart),
        .write_data(write_data),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Reference model: events as a byte queue, drain as "no strobe right after a strobe"
    logic [7:0]    mq[$];
    logic [NB-1:0] mpend;
    logic [NB-1:0] mg;
    bit            mwu, movf, mowe, mvalid, mfull;
    logic [7:0]    mwd, mseq;
    int            mgi;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mpend  = '0;
            mwu    = 1'b0;
            mwd    = 8'h00;
            movf   = 1'b0;
            mowe   = 1'b0;
            mseq   = 8'h00;
            mvalid = 1'b1;
        end else begin
            mfull = (mq.size() == D);
            if (mwu) begin
                mwu = 1'b0;
            end else if (mowe) begin
                if (!tx_full) begin
                    mwu  = 1'b1;
                    mwd  = mseq;
                    mseq = mseq + 8'd1;
                    mowe = 1'b0;
                end
            end else if (mq.size() > 0 && !tx_full) begin
                mwu  = 1'b1;
                mwd  = mq.pop_front();
                mowe = SEQ;
            end
            mgi = -1;
            for (int i = NB - 1; i >= 0; i--) if (mpend[i]) mgi = i;
            mg = '0;
            if (!mfull && mgi >= 0) mg[mgi] = 1'b1;
            if (|(btn_tick & mpend & ~mg)) movf = 1'b1;
            if (mg != '0) mq.push_back(8'(8'h30 + mgi));
            mpend = (mpend & ~mg) | btn_tick;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("write_uart", write_uart, mwu);
            chk("write_data", write_data, mwd);
            chk("fifo_count", fifo_count, mq.size());
            chk("overflow", overflow, movf);
        end
    end

    // Strobe log: code bytes and their cycles, sequence bytes separately
    logic [7:0] codes[$];
    logic [7:0] seqs[$];
    int         ctimes[$];
    int         nstrobe = 0;
    bit         par = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            par = 1'b0;
        end else if (write_uart) begin
            if (!SEQ || !par) begin
                codes.push_back(write_data);
                ctimes.push_back(cyc);
            end else begin
                seqs.push_back(write_data);
            end
            if (SEQ) par = ~par;
            nstrobe++;
        end
    end

    task automatic clear_log();
        codes.delete();
        seqs.delete();
        ctimes.delete();
    endtask

    function automatic int count_of(logic [7:0] b);
        int n = 0;
        foreach (codes[i]) if (codes[i] == b) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp2 [4] = '{8'h30, 8'h31, 8'h32, 8'h33};

    initial begin
        int w;
        int snap;
        reset = 1'b1;
        step(3);
        chk("rst_write_uart", write_uart, 0);
        chk("rst_write_data", write_data, 8'h00);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
        step(2);

        // 1: single press of button 2
        clear_log();
        btn_tick = 4'b0100;
        step(1);
        btn_tick = '0;
        step(1);
        chk("t1_count_n2", fifo_count, 1);
        chk("t1_wu_n2", write_uart, 0);
        step(1);
        chk("t1_wu_n3", write_uart, 1);
        chk("t1_wd_n3", write_data, 8'h32);
        step(10);
        chk("t1_nbytes", codes.size(), 1);
        if (codes.size() > 0) chk("t1_byte", codes[0], 8'h32);

        // 2: simultaneous press, sent in index order
        clear_log();
        btn_tick = 4'b1111;
        step(1);
        btn_tick = '0;
        step(30);
        chk("t2_nbytes", codes.size(), 4);
        for (int i = 0; i < 4 && i < codes.size(); i++) begin
            chk("t2_byte", codes[i], exp2[i]);
            if (i > 0) chk("t2_spacing", ctimes[i] - ctimes[i-1], GAP);
        end
        chk("t2_overflow", overflow, 0);

        // 3: backpressure, ninth press held pending
        clear_log();
        tx_full = 1'b1;
        for (int k = 0; k < 9; k++) begin
            btn_tick = 4'b0010;
            step(1);
            btn_tick = '0;
            step(3);
        end
        step(4);
        chk("t3_count_full", fifo_count, 8);
        chk("t3_nbytes_held", codes.size(), 0);
        chk("t3_overflow", overflow, 0);
        tx_full = 1'b0;
        step(9 * GAP + 20);
        chk("t3_nbytes", codes.size(), 9);
        chk("t3_n31", count_of(8'h31), 9);
        chk("t3_overflow_end", overflow, 0);
        chk("t3_count_end", fifo_count, 0);

        // 4: overflow on a coalesced press while the FIFO is full
        clear_log();
        tx_full = 1'b1;
        for (int k = 0; k < 8; k++) begin
            btn_tick = 4'b0100;
            step(1);
            btn_tick = '0;
            step(1);
        end
        step(3);
        chk("t4_count_full", fifo_count, 8);
        btn_tick = 4'b0001;
        step(1);
        btn_tick = '0;
        step(1);
        chk("t4_ovf_first", overflow, 0);
        btn_tick = 4'b0001;
        step(1);
        btn_tick = '0;
        step(1);
        chk("t4_ovf_second", overflow, 1);
        tx_full = 1'b0;
        step(60);
        chk("t4_n30", count_of(8'h30), 1);
        chk("t4_n32", count_of(8'h32), 8);
        chk("t4_ovf_sticky", overflow, 1);

        // 5: reset while a strobe is on the bus
        clear_log();
        tx_full = 1'b1;
        btn_tick = 4'b1111;
        step(1);
        btn_tick = '0;
        step(1);
        btn_tick = 4'b0001;
        step(1);
        btn_tick = '0;
        w = 0;
        while (fifo_count != 5 && w < 20) begin
            step(1);
            w++;
        end
        chk("t5_fill", fifo_count, 5);
        tx_full = 1'b0;
        w = 0;
        while (write_uart != 1'b1 && w < 10) begin
            step(1);
            w++;
        end
        chk("t5_strobe_seen", write_uart, 1);
        reset = 1'b1;
        step(1);
        chk("t5_wu", write_uart, 0);
        chk("t5_count", fifo_count, 0);
        chk("t5_wd", write_data, 8'h00);
        chk("t5_ovf", overflow, 0);
        reset = 1'b0;
        snap = nstrobe;
        step(30);
        chk("t5_no_strobes", nstrobe - snap, 0);
        chk("t5_count_end", fifo_count, 0);

`ifdef BTN_EVT_SEQ_EN
        // 6: sequence number wraps after 256 events
        clear_log();
        for (int k = 0; k < 257; k++) begin
            btn_tick = 4'b1000;
            step(1);
            btn_tick = '0;
            step(5);
        end
        step(20);
        chk("t6_ncodes", codes.size(), 257);
        chk("t6_nseqs", seqs.size(), 257);
        for (int i = 0; i < 257 && i < codes.size() && i < seqs.size(); i++) begin
            chk("t6_code", codes[i], 8'h33);
            chk("t6_seq", seqs[i], i % 256);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
